// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings, pipeline stage types and alignment helper
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } stage_t;

    // Data stage needs no address or size once the address phase has gone out.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic        write;
        logic [31:0] wdata;
    } dstage_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr_lsb[0];
            2'd2:    bad = (addr_lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// rtl/ahb_lite_master_if.sv - command/response stream and AHB-Lite bus signals of the initiator
interface ahb_lite_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRDATA
    );

endinterface

// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - two-stage pipelined AHB-Lite initiator issuing SINGLE transfers in order
module ahb_lite_master
    import ahb_pkg::*;
(
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_lite_master_if.master bus
);

    stage_t      a_q;
    dstage_t     d_q;
    stage_t      a_next;

    logic [31:0] haddr_q;
    logic [1:0]  htrans_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [31:0] hwdata_q;

    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    // Acceptance is purely HREADY so the caller can never form a loop through cmd_valid.
    assign bus.cmd_ready = bus.HREADY;

    always_comb begin
        a_next = '0;
        if (bus.cmd_valid) begin
            a_next.valid = 1'b1;
            a_next.err   = is_misaligned(bus.cmd_size, bus.cmd_addr[1:0]);
            a_next.write = bus.cmd_write;
            a_next.size  = bus.cmd_size;
            a_next.addr  = bus.cmd_addr;
            a_next.wdata = bus.cmd_wdata;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_q         <= '0;
            d_q         <= '0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= HSIZE_WORD;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            if (bus.HREADY) begin
                if (d_q.valid) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= d_q.err;
                    rsp_rdata_q <= (!d_q.err && !d_q.write) ? bus.HRDATA : 32'h0;
                end
                d_q.valid <= a_q.valid;
                d_q.err   <= a_q.err;
                d_q.write <= a_q.write;
                d_q.wdata <= a_q.wdata;
                if (a_q.valid && a_q.write) begin
                    hwdata_q <= a_q.wdata;
                end
                a_q <= a_next;
                // Rejected commands keep their pipeline slot but never reach the bus.
                if (a_next.valid && !a_next.err) begin
                    htrans_q <= HTRANS_NONSEQ;
                    haddr_q  <= a_next.addr;
                    hwrite_q <= a_next.write;
                    hsize_q  <= {1'b0, a_next.size};
                end else begin
                    htrans_q <= HTRANS_IDLE;
                end
            end
        end
    end

    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_DEFAULT;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = hwdata_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
